// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// Decode-stage hazard controller for a 5-stage MIPS pipeline. It detects the
// hazards that EX-stage bypassing cannot cover and holds the front of the
// pipeline until they clear:
//   - load-use RAW against a load sitting in EX,
//   - RAW/WAW against the single in-flight multi-cycle mul/div op,
//   - the structural busy of the mul/div unit.
// It also sequences that mul/div op and pulses md_done in its final cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   IF_ID_*             register fields / attributes of the decode instruction
//   ID_EX_MemRead/rt    load in EX and its destination
//   ID_EX_md_start/rd   mul/div issued into EX this cycle and its destination
//   branch_taken        younger instructions are being discarded
//   PCWrite/IF_ID_Write front-end enables (low while stalling)
//   IF_ID_flush         clear IF/ID to a nop
//   ID_EX_bubble        insert a nop into ID/EX
//   md_busy/md_done     mul/div unit occupied / result valid this cycle
//   md_wb_rd            destination of the mul/div op being tracked
//   md_overrun          sticky protocol-error flag (start while busy)
//   stall_cycles        saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic [4:0]       IF_ID_rd,
  input  logic             IF_ID_RegWrite,
  input  logic             IF_ID_is_md,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic             ID_EX_md_start,
  input  logic [4:0]       ID_EX_md_rd,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [4:0]       md_wb_rd,
  output logic             md_overrun,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  // Counter value loaded at issue; the op finishes when it reaches zero.
  localparam logic [7:0] LAT_M1  = 8'(MD_LATENCY - 1);
  // With a one-cycle latency the very first BUSY cycle is already the done cycle.
  localparam logic       LAT_ONE = (MD_LATENCY == 1) ? 1'b1 : 1'b0;

  md_state_t        r_state;
  logic [7:0]       r_cnt;
  logic             r_md_busy;
  logic             r_md_done;
  logic [4:0]       r_md_wb_rd;
  logic             r_md_overrun;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_load_use;
  logic w_md_dep;
  logic w_md_haz;
  logic w_stall;

  // Hazard detection. $0 never carries a real dependency, so it is excluded.
  assign w_load_use = ID_EX_MemRead & (ID_EX_rt != 5'd0) &
                      ((ID_EX_rt == IF_ID_rs) | (IF_ID_uses_rt & (ID_EX_rt == IF_ID_rt)));

  assign w_md_dep   = (r_md_wb_rd != 5'd0) &
                      ((r_md_wb_rd == IF_ID_rs) |
                       (IF_ID_uses_rt  & (r_md_wb_rd == IF_ID_rt)) |
                       (IF_ID_RegWrite & (r_md_wb_rd == IF_ID_rd)));

  // In the done cycle the result is written/forwarded, so nothing needs to wait.
  assign w_md_haz   = r_md_busy & ~r_md_done & (IF_ID_is_md | w_md_dep);

  // A taken branch discards the decode instruction, so its hazard is moot.
  assign w_stall    = (w_load_use | w_md_haz) & ~branch_taken;

  // Pipeline control outputs, forced to a safe hold-and-bubble state during reset.
  always_comb begin
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    ID_EX_bubble = 1'b1;
    IF_ID_flush  = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_bubble = 1'b1;
      IF_ID_flush  = 1'b0;
    end else begin
      PCWrite      = ~w_stall;
      IF_ID_Write  = ~w_stall;
      ID_EX_bubble = w_stall | branch_taken;
      IF_ID_flush  = branch_taken;
    end
  end

  // Mul/div tracking FSM, overrun flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_md_busy      <= 1'b0;
      r_md_done      <= 1'b0;
      r_md_wb_rd     <= 5'd0;
      r_md_overrun   <= 1'b0;
      r_stall_cycles <= {CNT_W{1'b0}};
    end else begin
      if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (ID_EX_md_start) begin
            r_state    <= ST_BUSY;
            r_cnt      <= LAT_M1;
            r_md_busy  <= 1'b1;
            r_md_done  <= LAT_ONE;
            r_md_wb_rd <= ID_EX_md_rd;
          end else begin
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt     <= r_cnt - 8'd1;
            // Done is registered so it lines up with the cycle where cnt reads zero.
            r_md_done <= (r_cnt == 8'd1);
            if (ID_EX_md_start) begin
              r_md_overrun <= 1'b1;
            end
          end else if (ID_EX_md_start) begin
            // Back-to-back issue in the done cycle: reload without going idle.
            r_state    <= ST_BUSY;
            r_cnt      <= LAT_M1;
            r_md_busy  <= 1'b1;
            r_md_done  <= LAT_ONE;
            r_md_wb_rd <= ID_EX_md_rd;
          end else begin
            r_state   <= ST_IDLE;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= 8'd0;
          r_md_busy <= 1'b0;
          r_md_done <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy      = r_md_busy;
  assign md_done      = r_md_done;
  assign md_wb_rd     = r_md_wb_rd;
  assign md_overrun   = r_md_overrun;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed bench for hazard_stall_unit (MD_LATENCY=4, CNT_W=4 so the stall
// counter saturation is reachable quickly). Inputs change 2 time units after
// a rising edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             IF_ID_uses_rt;
  logic [4:0]       IF_ID_rd;
  logic             IF_ID_RegWrite;
  logic             IF_ID_is_md;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_rt;
  logic             ID_EX_md_start;
  logic [4:0]       ID_EX_md_rd;
  logic             branch_taken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             md_busy;
  logic             md_done;
  logic [4:0]       md_wb_rd;
  logic             md_overrun;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .IF_ID_uses_rt (IF_ID_uses_rt),
    .IF_ID_rd      (IF_ID_rd),
    .IF_ID_RegWrite(IF_ID_RegWrite),
    .IF_ID_is_md   (IF_ID_is_md),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_rt      (ID_EX_rt),
    .ID_EX_md_start(ID_EX_md_start),
    .ID_EX_md_rd   (ID_EX_md_rd),
    .branch_taken  (branch_taken),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_flush   (IF_ID_flush),
    .ID_EX_bubble  (ID_EX_bubble),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .md_wb_rd      (md_wb_rd),
    .md_overrun    (md_overrun),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    IF_ID_rs       = 5'd0;
    IF_ID_rt       = 5'd0;
    IF_ID_uses_rt  = 1'b0;
    IF_ID_rd       = 5'd0;
    IF_ID_RegWrite = 1'b0;
    IF_ID_is_md    = 1'b0;
    ID_EX_MemRead  = 1'b0;
    ID_EX_rt       = 5'd0;
    ID_EX_md_start = 1'b0;
    ID_EX_md_rd    = 5'd0;
    branch_taken   = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_n        = 1'b0;
    branch_taken = 1'b1;

    // Reset: forced outputs and cleared registers
    tick(); #1;
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_ifid_write", IF_ID_Write, 0);
    chk("rst_bubble", ID_EX_bubble, 1);
    chk("rst_flush", IF_ID_flush, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_wb_rd", md_wb_rd, 0);
    chk("rst_overrun", md_overrun, 0);
    chk("rst_stall_cnt", stall_cycles, 0);

    branch_taken = 1'b0;
    rst_n        = 1'b1;
    tick(); #1;
    chk("idle_pcwrite", PCWrite, 1);
    chk("idle_bubble", ID_EX_bubble, 0);
    chk("idle_flush", IF_ID_flush, 0);

    // Load-use: lw $8 in EX, add rs=8 in decode
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
    #1;
    chk("lu_pcwrite", PCWrite, 0);
    chk("lu_ifid_write", IF_ID_Write, 0);
    chk("lu_bubble", ID_EX_bubble, 1);
    tick();
    ID_EX_MemRead = 1'b0;
    #1;
    chk("lu_after_pcwrite", PCWrite, 1);
    chk("lu_after_bubble", ID_EX_bubble, 0);
    chk("lu_stall_cnt", stall_cycles, 1);

    // Load to $0 never stalls
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_uses_rt = 1'b1;
    #1;
    chk("lu_r0_pcwrite", PCWrite, 1);
    // rt match only counts when rt is actually read
    ID_EX_rt = 5'd8; IF_ID_rs = 5'd3; IF_ID_rt = 5'd8; IF_ID_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", PCWrite, 1);
    IF_ID_uses_rt = 1'b1;
    #1;
    chk("lu_sw_rt", PCWrite, 0);
    tick(); #1;
    chk("lu_sw_stall_cnt", stall_cycles, 2);

    // Branch overrides the stall
    branch_taken = 1'b1;
    #1;
    chk("br_flush", IF_ID_flush, 1);
    chk("br_bubble", ID_EX_bubble, 1);
    chk("br_pcwrite", PCWrite, 1);
    tick();
    clear_inputs();
    #1;
    chk("br_stall_cnt", stall_cycles, 2);

    // MD op rd=5 issued at T; dependents stall T+1..T+3
    ID_EX_md_start = 1'b1; ID_EX_md_rd = 5'd5;
    tick();                                           // T+1
    ID_EX_md_start = 1'b0; IF_ID_rs = 5'd5;
    #1;
    chk("md_busy_t1", md_busy, 1);
    chk("md_done_t1", md_done, 0);
    chk("md_raw_rs", PCWrite, 0);
    tick();                                           // T+2
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd5; IF_ID_uses_rt = 1'b1;
    #1;
    chk("md_raw_rt", PCWrite, 0);
    tick();                                           // T+3
    IF_ID_rt = 5'd0; IF_ID_uses_rt = 1'b0; IF_ID_RegWrite = 1'b1; IF_ID_rd = 5'd5;
    #1;
    chk("md_waw", PCWrite, 0);
    chk("md_stall_cnt_t3", stall_cycles, 4);
    tick(); #1;                                       // T+4
    chk("md_done_t4", md_done, 1);
    chk("md_wb_rd_t4", md_wb_rd, 5);
    chk("md_done_no_stall", PCWrite, 1);
    chk("md_stall_cnt_t4", stall_cycles, 5);
    tick();                                           // T+5
    clear_inputs();
    #1;
    chk("md_busy_t5", md_busy, 0);
    chk("md_done_t5", md_done, 0);

    // Structural busy, back-to-back issue, then an overrun
    ID_EX_md_start = 1'b1; ID_EX_md_rd = 5'd6;        // U
    tick();                                           // U+1
    ID_EX_md_start = 1'b0; IF_ID_is_md = 1'b1;
    #1;
    chk("struct_pcwrite", PCWrite, 0);
    chk("struct_bubble", ID_EX_bubble, 1);
    tick(); tick(); #1;                               // U+3
    chk("struct_pcwrite_u3", PCWrite, 0);
    tick(); #1;                                       // U+4
    chk("b2b_done", md_done, 1);
    chk("b2b_pcwrite", PCWrite, 1);
    chk("b2b_stall_cnt", stall_cycles, 8);
    ID_EX_md_start = 1'b1; ID_EX_md_rd = 5'd7;
    tick();                                           // U+5
    ID_EX_md_start = 1'b0; IF_ID_is_md = 1'b0;
    #1;
    chk("b2b_busy", md_busy, 1);
    chk("b2b_done_u5", md_done, 0);
    chk("b2b_wb_rd", md_wb_rd, 7);
    chk("b2b_no_overrun", md_overrun, 0);
    tick();                                           // U+6, cnt=2
    ID_EX_md_start = 1'b1; ID_EX_md_rd = 5'd9;
    tick();                                           // U+7
    ID_EX_md_start = 1'b0;
    #1;
    chk("ovr_flag", md_overrun, 1);
    chk("ovr_wb_rd_kept", md_wb_rd, 7);
    chk("ovr_busy", md_busy, 1);
    tick(); #1;                                       // U+8
    chk("ovr_done", md_done, 1);
    tick(); #1;                                       // U+9
    chk("ovr_idle", md_busy, 0);
    chk("ovr_sticky", md_overrun, 1);

    // Reset in the middle of an MD op
    ID_EX_md_start = 1'b1; ID_EX_md_rd = 5'd10;       // V
    tick();                                           // V+1
    ID_EX_md_start = 1'b0;
    #1;
    chk("mr_busy", md_busy, 1);
    tick();                                           // V+2
    rst_n = 1'b0;
    #1;
    chk("mr_rst_pcwrite", PCWrite, 0);
    chk("mr_rst_bubble", ID_EX_bubble, 1);
    chk("mr_rst_ifid_write", IF_ID_Write, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_busy_cleared", md_busy, 0);
    chk("mr_overrun_cleared", md_overrun, 0);
    chk("mr_wb_rd_cleared", md_wb_rd, 0);
    chk("mr_stall_cnt_cleared", stall_cycles, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("mr_no_done", md_done, 0);
    end

    // Destination $0: only the structural busy applies
    ID_EX_md_start = 1'b1; ID_EX_md_rd = 5'd0;
    tick();
    ID_EX_md_start = 1'b0; IF_ID_uses_rt = 1'b1; IF_ID_RegWrite = 1'b1;
    #1;
    chk("r0_no_raw", PCWrite, 1);
    IF_ID_is_md = 1'b1;
    #1;
    chk("r0_struct", PCWrite, 0);
    tick();
    clear_inputs();
    #1;
    chk("r0_stall_cnt", stall_cycles, 1);

    // Stall counter saturates at all-ones
    ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
    repeat (10) tick();
    #1;
    chk("sat_mid", stall_cycles, 11);
    repeat (10) tick();
    #1;
    chk("sat_full", stall_cycles, 15);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
